// File: rtl/row_scan_ctrl_pkg.sv
// Shared definitions for the row scan controller: default widths and FSM state encoding.
package row_scan_ctrl_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

endpackage : row_scan_ctrl_pkg

// File: rtl/row_scan_ctrl_if.sv
// Control/status bundle between a scan requester (master) and row_scan_ctrl (slave).
interface row_scan_if
  import row_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) ();

  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [ADDR_W-1:0]  last_row;
  logic [ADDR_W-1:0]  row_addr;
  logic               row_enable;
  logic               busy;
  logic               frame_done;

  modport master (
    output start, stop, dwell, last_row,
    input  row_addr, row_enable, busy, frame_done
  );

  modport slave (
    input  start, stop, dwell, last_row,
    output row_addr, row_enable, busy, frame_done
  );

endinterface : row_scan_if

// File: rtl/row_scan_ctrl.sv
// Row scan controller: steps a registered row address through 0..last_row with a one-cycle
// blank before each row and a programmable drive length, feeding a 5-to-32 decoder directly.
module row_scan_ctrl
  import row_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  row_scan_if.slave  bus
);

  state_e             state_q,        state_d;
  logic [ADDR_W-1:0]  row_addr_q,     row_addr_d;
  logic               row_enable_q,   row_enable_d;
  logic               frame_done_q,   frame_done_d;
  logic               stop_pending_q, stop_pending_d;
  logic [DWELL_W-1:0] dwell_cnt_q,    dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_cap_q,    dwell_cap_d;
  logic [ADDR_W-1:0]  last_row_cap_q, last_row_cap_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    row_addr_d     = row_addr_q;
    row_enable_d   = 1'b0;
    frame_done_d   = 1'b0;
    stop_pending_d = stop_pending_q;
    dwell_cnt_d    = dwell_cnt_q;
    dwell_cap_d    = dwell_cap_q;
    last_row_cap_d = last_row_cap_q;

    if (state_q != ST_IDLE && bus.stop) begin
      stop_pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dwell_cap_d    = bus.dwell;
          last_row_cap_d = bus.last_row;
          row_addr_d     = '0;
          stop_pending_d = 1'b0;
          state_d        = ST_BLANK;
        end
      end

      ST_BLANK: begin
        dwell_cnt_d  = dwell_cap_q;
        row_enable_d = 1'b1;
        state_d      = ST_DRIVE;
      end

      ST_DRIVE: begin
        if (dwell_cnt_q == '0) begin
          // Address only moves here, as the enable drops for the following blank cycle.
          if (row_addr_q == last_row_cap_q) begin
            row_addr_d   = '0;
            frame_done_d = 1'b1;
            state_d      = stop_pending_d ? ST_IDLE : ST_BLANK;
          end else begin
            row_addr_d = row_addr_q + ADDR_W'(1);
            state_d    = ST_BLANK;
          end
        end else begin
          dwell_cnt_d  = dwell_cnt_q - DWELL_W'(1);
          row_enable_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; async reset clears every flop,
  // which is what drops row_enable mid-drive without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      row_addr_q     <= '0;
      row_enable_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      stop_pending_q <= 1'b0;
      dwell_cnt_q    <= '0;
      dwell_cap_q    <= '0;
      last_row_cap_q <= '0;
    end else begin
      state_q        <= state_d;
      row_addr_q     <= row_addr_d;
      row_enable_q   <= row_enable_d;
      frame_done_q   <= frame_done_d;
      stop_pending_q <= stop_pending_d;
      dwell_cnt_q    <= dwell_cnt_d;
      dwell_cap_q    <= dwell_cap_d;
      last_row_cap_q <= last_row_cap_d;
    end
  end

  assign bus.row_addr   = row_addr_q;
  assign bus.row_enable = row_enable_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule : row_scan_ctrl

// File: tb/tb_row_scan_ctrl.sv
// Directed self-checking bench for row_scan_ctrl: expected values are hand-derived cycle by cycle.
module tb_row_scan_ctrl;
  import row_scan_ctrl_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DWELL_W_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  row_scan_if #(.ADDR_W(AW), .DWELL_W(DW)) sif ();

  row_scan_ctrl #(.ADDR_W(AW), .DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int addr, input int en, input int busy,
                           input int fd);
    check({tag, ".row_addr"},   int'(sif.row_addr),   addr);
    check({tag, ".row_enable"}, int'(sif.row_enable), en);
    check({tag, ".busy"},       int'(sif.busy),       busy);
    check({tag, ".frame_done"}, int'(sif.frame_done), fd);
  endtask

  initial begin
    int          cnt;
    int          bad;
    int          en_r5;
    bit          found;
    logic        prev_en;
    logic [AW-1:0] prev_addr;

    sif.start    = 1'b0;
    sif.stop     = 1'b0;
    sif.dwell    = '0;
    sif.last_row = '0;

    // Reset state
    #1;
    check_out("reset", 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    // dwell=0, last_row=1: start sampled on edge 0
    sif.dwell    = 8'd0;
    sif.last_row = 5'd1;
    sif.start    = 1'b1;
    step();
    sif.start = 1'b0;
    check_out("a_e0", 0, 0, 1, 0);
    step(); check_out("a_e1", 0, 1, 1, 0);
    step(); check_out("a_e2", 1, 0, 1, 0);
    step(); check_out("a_e3", 1, 1, 1, 0);
    step(); check_out("a_e4", 0, 0, 1, 1);
    step(); check_out("a_e5", 0, 1, 1, 0);
    // stop during DRIVE of row 0: frame still finishes through row 1
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    check_out("a_e6", 1, 0, 1, 0);
    step(); check_out("a_e7", 1, 1, 1, 0);
    step(); check_out("a_e8", 0, 0, 0, 1);
    step(); check_out("a_e9", 0, 0, 0, 0);
    // stop while idle is ignored
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    check_out("idle_stop", 0, 0, 0, 0);

    // dwell=3, last_row=31: 160-cycle frame; new inputs and start while busy are ignored
    sif.dwell    = 8'd3;
    sif.last_row = 5'd31;
    sif.start    = 1'b1;
    step();
    sif.dwell    = 8'd0;
    sif.last_row = 5'd2;
    cnt = 0; bad = 0; en_r5 = 0;
    prev_addr = sif.row_addr;
    for (int i = 0; i < 400; i++) begin
      step();
      cnt++;
      if (sif.row_addr != prev_addr && sif.row_enable) bad++;
      if (sif.row_enable && sif.row_addr == 5'd5) en_r5++;
      if (sif.frame_done) break;
      prev_addr = sif.row_addr;
    end
    check("b_frame_len", cnt, 160);
    check("b_wrap_from", int'(prev_addr), 31);
    check("b_wrap_to", int'(sif.row_addr), 0);
    check("b_addr_stable_while_en", bad, 0);
    check("b_row5_drive_cycles", en_r5, 4);

    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      cnt++;
      if (sif.frame_done) break;
    end
    check("b_frame2_len", cnt, 160);
    check("b_frame2_busy", int'(sif.busy), 1);
    sif.start = 1'b0;

    // stop at row 5: frame completes, busy drops right after the final DRIVE cycle
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sif.row_addr == 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("c_reach_row5", int'(found), 1);
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    found = 1'b0;
    prev_en = sif.row_enable;
    prev_addr = sif.row_addr;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!sif.busy) begin
        found = 1'b1;
        break;
      end
      prev_en = sif.row_enable;
      prev_addr = sif.row_addr;
    end
    check("c_went_idle", int'(found), 1);
    check("c_idle_fd", int'(sif.frame_done), 1);
    check("c_prev_en", int'(prev_en), 1);
    check("c_prev_addr", int'(prev_addr), 31);
    check("c_idle_addr", int'(sif.row_addr), 0);
    step();
    check_out("c_after", 0, 0, 0, 0);

    // restart picks up dwell=0, last_row=2: 6-cycle frame
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cnt++;
      if (sif.frame_done) break;
    end
    check("d_new_frame_len", cnt, 6);
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!sif.busy) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("d_stopped", int'(found), 1);

    // start and stop together in IDLE, last_row=0: frame_done after every drive, keeps running
    sif.dwell    = 8'd0;
    sif.last_row = 5'd0;
    sif.start    = 1'b1;
    sif.stop     = 1'b1;
    step();
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    check_out("e_e0", 0, 0, 1, 0);
    step(); check_out("e_e1", 0, 1, 1, 0);
    step(); check_out("e_e2", 0, 0, 1, 1);
    step(); check_out("e_e3", 0, 1, 1, 0);
    step(); check_out("e_e4", 0, 0, 1, 1);
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    check_out("e_e5", 0, 1, 1, 0);
    step(); check_out("e_e6", 0, 0, 0, 1);

    // async reset during DRIVE of row 7
    sif.dwell    = 8'd3;
    sif.last_row = 5'd31;
    sif.start    = 1'b1;
    step();
    sif.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sif.row_addr == 5'd7 && sif.row_enable) begin
        found = 1'b1;
        break;
      end
    end
    check("f_reach_row7", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check_out("f_in_reset", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step();
    step();
    step();
    check_out("f_after_release", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_row_scan_ctrl

// File: doc/row_scan_ctrl.md
ROW_SCAN_CTRL -- requirements
Module: row_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, row-address width matching the 5-to-32 decoder input.
REQ-002 The block SHALL have parameter DWELL_W, default 8, width of the per-row dwell count.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level-sampled request to begin scanning.
REQ-007 stop  input  1  request to halt at the end of the current frame.
REQ-008 dwell  input  DWELL_W  per-row drive length minus one, sampled on accepted start.
REQ-009 last_row  input  ADDR_W  highest row index scanned, sampled on accepted start.
REQ-010 row_addr  output  ADDR_W  registered binary row index, drives the decoder IN bus.
REQ-011 row_enable  output  1  registered decoder enable, high only while a row is driven.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_done  output  1  single-cycle pulse marking completion of a full frame.

Function
REQ-014 The state machine SHALL have three states: IDLE, BLANK, DRIVE.
REQ-015 In IDLE, start=1 SHALL be accepted: capture dwell and last_row, set row_addr=0, clear stop_pending, next state BLANK.
REQ-016 BLANK SHALL last exactly one cycle with row_enable=0, then go to DRIVE; row_addr SHALL change only on entry to BLANK, never while row_enable=1.
REQ-017 DRIVE SHALL hold row_enable=1 for exactly captured dwell+1 cycles (dwell=0 -> 1 cycle, dwell=255 -> 256 cycles) using an internal down-counter.
REQ-018 On DRIVE exit with row_addr!=last_row, row_addr SHALL increment by 1 and state SHALL be BLANK.
REQ-019 On DRIVE exit with row_addr==last_row, row_addr SHALL wrap to 0, frame_done SHALL be high for the next cycle only, and state SHALL be IDLE if stop_pending else BLANK.
REQ-020 stop=1 in BLANK or DRIVE SHALL set stop_pending, which is cleared only on accepted start or reset; the current frame always completes.
REQ-021 stop in IDLE SHALL be ignored; simultaneous start and stop in IDLE SHALL start scanning with stop_pending clear.
REQ-022 start while busy SHALL be ignored; changes to dwell or last_row while busy SHALL have no effect until the next accepted start.
REQ-023 last_row=0 SHALL scan row 0 only, producing frame_done after every DRIVE.
REQ-024 busy SHALL be combinationally decoded from state; all other outputs SHALL be registered.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, row_addr=0, row_enable=0, frame_done=0, stop_pending=0, dwell counter=0, captured registers=0.
REQ-026 Reset asserted mid-DRIVE SHALL drop row_enable within the same cycle, without waiting for a clock edge; the block SHALL remain IDLE after release until a new start.

Structure
REQ-027 State encoding (IDLE, BLANK, DRIVE) and ADDR_W default SHALL live in a shared package.
REQ-028 The block SHALL be a single module; the dwell down-counter is inline, no sub-module.
REQ-029 The block SHALL connect directly to decoder5x32 (row_enable to enable, row_addr to IN) with no glue logic.

Verification
REQ-030 dwell=0, last_row=1, start pulse at edge 0 -> edges 1..4: (row0,en0),(row0,en1),(row1,en0),(row1,en1); frame_done=1 at edge 5 only; scan repeats.
REQ-031 dwell=3, last_row=31 -> each row driven 4 cycles, 32 rows, frame length 160 cycles, row_addr wraps 31->0.
REQ-032 stop pulsed mid-frame at row 5 -> frame finishes through last_row, frame_done pulses, busy=0 in the cycle after the final DRIVE cycle.
REQ-033 start and stop asserted together in IDLE -> scanning starts and continues past first frame_done.
REQ-034 rst_n low during DRIVE of row 7 -> row_enable=0 and row_addr=0 before next edge; IDLE held after release.
REQ-035 dwell and last_row changed while busy -> timing unchanged until stop, return to IDLE, and re-start.
